// File: rtl/mem_arbiter_pkg.sv
// Shared types for the I/D memory-port arbiter: FSM states and grant sources.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } arb_state_t;

    typedef enum logic {
        SRC_I = 1'b0,
        SRC_D = 1'b1
    } arb_src_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational tie-breaker: picks I or D from the live requests and the previous winner.
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic     i_req,
    input  logic     d_req,
    input  arb_src_t last_grant,
    input  logic     rr,
    output arb_src_t grant,
    output logic     valid
);

    always_comb begin
        valid = i_req | d_req;
        grant = SRC_I;
        if (i_req && d_req) begin
            // Round-robin hands the tie to whoever did not win last; fixed mode favours D.
            if (rr) grant = (last_grant == SRC_I) ? SRC_D : SRC_I;
            else    grant = SRC_D;
        end else if (d_req) begin
            grant = SRC_D;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between I and D requesters, one transaction in flight at a time.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 32,
    parameter int RR     = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_read,
    input  logic                i_write,
    input  logic [WIDTH/8-1:0]  i_byte_enable,
    input  logic [ADDR_W-1:0]   i_address,
    input  logic [WIDTH-1:0]    i_wdata,
    output logic                i_resp,
    output logic [WIDTH-1:0]    i_rdata,
    input  logic                d_read,
    input  logic                d_write,
    input  logic [WIDTH/8-1:0]  d_byte_enable,
    input  logic [ADDR_W-1:0]   d_address,
    input  logic [WIDTH-1:0]    d_wdata,
    output logic                d_resp,
    output logic [WIDTH-1:0]    d_rdata,
    output logic                mem_read,
    output logic                mem_write,
    output logic [WIDTH/8-1:0]  mem_byte_enable,
    output logic [ADDR_W-1:0]   mem_address,
    output logic [WIDTH-1:0]    mem_wdata,
    input  logic                mem_resp,
    input  logic [WIDTH-1:0]    mem_rdata
);

    localparam int BE_W = WIDTH / 8;

    arb_state_t          state_q, state_d;
    arb_src_t            last_q, last_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [BE_W-1:0]     mem_be_q, mem_be_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [WIDTH-1:0]    mem_wdata_q, mem_wdata_d;

    arb_src_t pick_grant;
    logic     pick_valid;

    arb_pick u_pick (
        .i_req      (i_read | i_write),
        .d_req      (d_read | d_write),
        .last_grant (last_q),
        .rr         (RR != 0),
        .grant      (pick_grant),
        .valid      (pick_valid)
    );

    always_comb begin
        state_d     = state_q;
        last_d      = last_q;
        mem_read_d  = mem_read_q;
        mem_write_d = mem_write_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    last_d = pick_grant;
                    // Write wins over read so the port never sees both strobes.
                    if (pick_grant == SRC_I) begin
                        state_d     = SERVE_I;
                        mem_write_d = i_write;
                        mem_read_d  = i_read & ~i_write;
                        mem_be_d    = i_byte_enable;
                        mem_addr_d  = i_address;
                        mem_wdata_d = i_wdata;
                    end else begin
                        state_d     = SERVE_D;
                        mem_write_d = d_write;
                        mem_read_d  = d_read & ~d_write;
                        mem_be_d    = d_byte_enable;
                        mem_addr_d  = d_address;
                        mem_wdata_d = d_wdata;
                    end
                end
            end
            SERVE_I, SERVE_D: begin
                if (mem_resp) begin
                    state_d     = IDLE;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_q      <= SRC_D;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign mem_read        = mem_read_q;
    assign mem_write       = mem_write_q;
    assign mem_byte_enable = mem_be_q;
    assign mem_address     = mem_addr_q;
    assign mem_wdata       = mem_wdata_q;

    assign i_resp  = (state_q == SERVE_I) && mem_resp;
    assign d_resp  = (state_q == SERVE_D) && mem_resp;
    assign i_rdata = (state_q == SERVE_I) ? mem_rdata : '0;
    assign d_rdata = (state_q == SERVE_D) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a round-robin and a fixed-priority instance share one stimulus.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        i_read = 0, i_write = 0, d_read = 0, d_write = 0;
    logic [3:0]  i_be = 0, d_be = 0;
    logic [31:0] i_addr = 0, d_addr = 0, i_wd = 0, d_wd = 0;
    logic        mem_resp = 0;
    logic [31:0] mem_rdata = 0;

    logic        r_iresp, r_dresp, r_mrd, r_mwr;
    logic [31:0] r_irdata, r_drdata, r_maddr, r_mwd;
    logic [3:0]  r_mbe;
    logic        f_iresp, f_dresp, f_mrd, f_mwr;
    logic [31:0] f_irdata, f_drdata, f_maddr, f_mwd;
    logic [3:0]  f_mbe;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.WIDTH(32), .ADDR_W(32), .RR(1)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_write(i_write), .i_byte_enable(i_be), .i_address(i_addr), .i_wdata(i_wd),
        .i_resp(r_iresp), .i_rdata(r_irdata),
        .d_read(d_read), .d_write(d_write), .d_byte_enable(d_be), .d_address(d_addr), .d_wdata(d_wd),
        .d_resp(r_dresp), .d_rdata(r_drdata),
        .mem_read(r_mrd), .mem_write(r_mwr), .mem_byte_enable(r_mbe), .mem_address(r_maddr),
        .mem_wdata(r_mwd), .mem_resp(mem_resp), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.WIDTH(32), .ADDR_W(32), .RR(0)) u_fp (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_write(i_write), .i_byte_enable(i_be), .i_address(i_addr), .i_wdata(i_wd),
        .i_resp(f_iresp), .i_rdata(f_irdata),
        .d_read(d_read), .d_write(d_write), .d_byte_enable(d_be), .d_address(d_addr), .d_wdata(d_wd),
        .d_resp(f_dresp), .d_rdata(f_drdata),
        .mem_read(f_mrd), .mem_write(f_mwr), .mem_byte_enable(f_mbe), .mem_address(f_maddr),
        .mem_wdata(f_mwd), .mem_resp(mem_resp), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        rst_n = 1'b0;
        tick(); tick();
        chk("rst_mem_read",  {31'b0, r_mrd}, 32'd0);
        chk("rst_mem_write", {31'b0, r_mwr}, 32'd0);
        chk("rst_mem_addr",  r_maddr, 32'd0);
        chk("rst_mem_wdata", r_mwd, 32'd0);
        chk("rst_mem_be",    {28'b0, r_mbe}, 32'd0);
        chk("rst_resps",     {30'b0, r_iresp, r_dresp}, 32'd0);
        rst_n = 1'b1;
        tick();

        // I-only read, memory answers in the third serve cycle
        i_read = 1; i_addr = 32'h60; i_be = 4'hF;
        tick();
        chk("i_rd_strobe", {31'b0, r_mrd}, 32'd1);
        chk("i_rd_write",  {31'b0, r_mwr}, 32'd0);
        chk("i_rd_addr",   r_maddr, 32'h60);
        chk("i_rd_be",     {28'b0, r_mbe}, 32'hF);
        chk("i_rd_noresp", {31'b0, r_iresp}, 32'd0);
        tick(); tick();
        chk("i_rd_hold",   {31'b0, r_mrd}, 32'd1);
        mem_resp = 1; mem_rdata = 32'hDEADBEEF;
        #1;
        chk("i_rd_resp",   {31'b0, r_iresp}, 32'd1);
        chk("i_rd_rdata",  r_irdata, 32'hDEADBEEF);
        chk("i_rd_dresp",  {31'b0, r_dresp}, 32'd0);
        chk("i_rd_drdata", r_drdata, 32'd0);
        tick();
        mem_resp = 0; i_read = 0;
        #1;
        chk("i_rd_strobe_drop", {31'b0, r_mrd}, 32'd0);
        chk("i_rd_resp_drop",   {31'b0, r_iresp}, 32'd0);

        // mem_resp while idle produces no client response
        mem_resp = 1;
        #1;
        chk("idle_resp_ignored", {30'b0, r_iresp, r_dresp}, 32'd0);
        tick();
        mem_resp = 0;

        // D write with partial byte enables
        d_write = 1; d_addr = 32'h100; d_be = 4'b0011; d_wd = 32'h1234_5678;
        tick();
        chk("d_wr_strobe", {31'b0, r_mwr}, 32'd1);
        chk("d_wr_read",   {31'b0, r_mrd}, 32'd0);
        chk("d_wr_addr",   r_maddr, 32'h100);
        chk("d_wr_be",     {28'b0, r_mbe}, 32'h3);
        chk("d_wr_wdata",  r_mwd, 32'h1234_5678);
        tick();
        chk("d_wr_noresp", {31'b0, r_dresp}, 32'd0);
        mem_resp = 1;
        #1;
        chk("d_wr_resp",   {31'b0, r_dresp}, 32'd1);
        chk("d_wr_iresp",  {31'b0, r_iresp}, 32'd0);
        tick();
        mem_resp = 0; d_write = 0;
        #1;
        chk("d_wr_resp_pulse", {31'b0, r_dresp}, 32'd0);
        chk("d_wr_strobe_drop", {31'b0, r_mwr}, 32'd0);

        // Read+write together issues a write only
        i_read = 1; i_write = 1; i_addr = 32'h1C; i_wd = 32'hCAFE_0001;
        tick();
        chk("rw_write", {31'b0, r_mwr}, 32'd1);
        chk("rw_read",  {31'b0, r_mrd}, 32'd0);
        mem_resp = 1;
        tick();
        mem_resp = 0; i_read = 0; i_write = 0;

        // Simultaneous requests out of reset: RR grants I first, fixed grants D
        do_reset();
        i_read = 1; i_addr = 32'h200; d_read = 1; d_addr = 32'h300;
        tick();
        chk("tie_rr_first",  r_maddr, 32'h200);
        chk("tie_fp_first",  f_maddr, 32'h300);
        tick();
        chk("tie_rr_hold",   r_maddr, 32'h200);
        mem_resp = 1; mem_rdata = 32'h0000_AAAA;
        #1;
        chk("tie_rr_iresp",  {31'b0, r_iresp}, 32'd1);
        chk("tie_rr_dresp0", {31'b0, r_dresp}, 32'd0);
        tick();
        mem_resp = 0; i_read = 0;
        #1;
        chk("tie_idle_gap",  {31'b0, r_mrd}, 32'd0);
        chk("tie_addr_held", r_maddr, 32'h200);
        tick();
        chk("tie_rr_second", r_maddr, 32'h300);
        chk("tie_rr_rd2",    {31'b0, r_mrd}, 32'd1);
        mem_resp = 1; mem_rdata = 32'h0000_BBBB;
        #1;
        chk("tie_rr_dresp",  {31'b0, r_dresp}, 32'd1);
        chk("tie_rr_drdata", r_drdata, 32'h0000_BBBB);
        tick();
        mem_resp = 0; d_read = 0;
        tick();

        // Continuous contention: RR alternates, fixed priority always serves D
        do_reset();
        i_read = 1; i_addr = 32'h400; d_read = 1; d_addr = 32'h500;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk($sformatf("cont_rr_addr%0d", k), r_maddr, (k % 2 == 0) ? 32'h400 : 32'h500);
            chk($sformatf("cont_fp_addr%0d", k), f_maddr, 32'h500);
            mem_resp = 1;
            #1;
            chk($sformatf("cont_fp_dresp%0d", k), {31'b0, f_dresp}, 32'd1);
            chk($sformatf("cont_fp_iresp%0d", k), {31'b0, f_iresp}, 32'd0);
            tick();
            mem_resp = 0;
        end
        i_read = 0; d_read = 0;
        tick();

        // Address change mid-serve is not seen by memory
        i_read = 1; i_addr = 32'h40;
        tick();
        chk("midserve_addr0", r_maddr, 32'h40);
        i_addr = 32'h80;
        tick();
        chk("midserve_addr1", r_maddr, 32'h40);
        mem_resp = 1;
        #1;
        chk("midserve_addr2", r_maddr, 32'h40);
        chk("midserve_resp",  {31'b0, r_iresp}, 32'd1);
        tick();
        mem_resp = 0; i_read = 0;
        tick();

        // Reset during SERVE_D, then a stale mem_resp two cycles later
        d_read = 1; d_addr = 32'h600;
        tick();
        chk("abort_serving", {31'b0, r_mrd}, 32'd1);
        rst_n = 0; d_read = 0;
        tick();
        rst_n = 1;
        chk("abort_strobe_drop", {31'b0, r_mrd}, 32'd0);
        chk("abort_addr_clear",  r_maddr, 32'd0);
        tick();
        mem_resp = 1;
        #1;
        chk("abort_no_resp",  {30'b0, r_iresp, r_dresp}, 32'd0);
        chk("abort_idle",     {31'b0, u_rr.state_q === IDLE}, 32'd1);
        chk("abort_last_d",   {31'b0, u_rr.last_q === SRC_D}, 32'd1);
        tick();
        mem_resp = 0;
        i_read = 1; i_addr = 32'h700; d_read = 1; d_addr = 32'h800;
        tick();
        chk("abort_tie_i_wins", r_maddr, 32'h700);
        mem_resp = 1;
        tick();
        mem_resp = 0; i_read = 0; d_read = 0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
